rx_edge_bit_sampler: RTL

//   Timing and sampling front end of the UART receiver, directly upstream of the RX FSM.
//   - Counts oversampling edges per bit and bits per frame, and drives edge_cnt/bit_cnt to the FSM.
//   - Recovers each serial bit by sampling around mid-bit and holds it on sampled_bit
//     for the start/data/parity/stop checkers and the deserializer.

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/rx_mid_sampler.sv | 41 ++++
 rtl/rx_edge_bit_sampler.sv | 48 ++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared widths, legal prescale values and frame bit indices for the UART receiver
package uart_rx_pkg;
  localparam int PRESC_W = 6;
  localparam int BITCNT_W = 4;
  localparam logic [PRESC_W-1:0] PRESC_8 = 6'd8;
  localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;
  localparam logic [BITCNT_W-1:0] BIT_START = 4'd0;
  localparam logic [BITCNT_W-1:0] BIT_DATA_LAST = 4'd8;
  localparam logic [BITCNT_W-1:0] BIT_LAST_NOPAR = 4'd9;
  localparam logic [BITCNT_W-1:0] BIT_LAST_PAR = 4'd10;
endpackage

// File: rtl/rx_mid_sampler.sv
// rx_mid_sampler: mid-bit capture and vote; RX_MAJORITY_VOTE_EN selects 2-of-3 majority, else single sample at H
module rx_mid_sampler
  import uart_rx_pkg::*;
(
  input  logic               clk,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               dat_samp_en,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  output logic               sampled_bit,
  output logic               sample_vld
);
  logic [PRESC_W-1:0] h;
  logic s1_q, bit_q, vote;
  assign h = Prescale >> 1;
  assign sample_vld = dat_samp_en && edge_cnt == h + PRESC_W'(2);
  assign sampled_bit = bit_q;
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      s1_q <= 1'b1;
      bit_q <= 1'b1;
    end else if (dat_samp_en) begin
      if (edge_cnt == h) s1_q <= RX_IN;
      if (sample_vld) bit_q <= vote;
    end
`ifdef RX_MAJORITY_VOTE_EN
  logic s0_q, s2_q;
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      s0_q <= 1'b1;
      s2_q <= 1'b1;
    end else if (dat_samp_en) begin
      if (edge_cnt == h - PRESC_W'(1)) s0_q <= RX_IN;
      if (edge_cnt == h + PRESC_W'(1)) s2_q <= RX_IN;
    end
  assign vote = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
`else
  assign vote = s1_q;
`endif
endmodule

// File: rtl/rx_edge_bit_sampler.sv
// rx_edge_bit_sampler: oversampling edge/bit counters for the RX FSM plus mid-bit sampler
// (macro RX_MAJORITY_VOTE_EN enables the 3-sample majority vote in rx_mid_sampler)
module rx_edge_bit_sampler
  import uart_rx_pkg::*;
(
  input  logic                clk,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic                enable,
  input  logic                dat_samp_en,
  input  logic                PAR_EN,
  input  logic [PRESC_W-1:0]  Prescale,
  output logic [PRESC_W-1:0]  edge_cnt,
  output logic [BITCNT_W-1:0] bit_cnt,
  output logic                sampled_bit,
  output logic                sample_vld
);
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BITCNT_W-1:0] bit_q, bit_d, last;
  logic wrap;
  // wrap back to BIT_START after the last bit is what releases the FSM from STOP
  always_comb begin
    last = PAR_EN ? BIT_LAST_PAR : BIT_LAST_NOPAR;
    wrap = edge_q == Prescale - PRESC_W'(1);
    edge_d = (!enable || wrap) ? '0 : edge_q + PRESC_W'(1);
    bit_d = !enable ? BIT_START : !wrap ? bit_q : (bit_q < last) ? bit_q + BITCNT_W'(1) : BIT_START;
  end
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      edge_q <= '0;
      bit_q <= BIT_START;
    end else begin
      edge_q <= edge_d;
      bit_q <= bit_d;
    end
  assign edge_cnt = edge_q;
  assign bit_cnt = bit_q;
  rx_mid_sampler u_samp (
    .clk(clk),
    .RST(RST),
    .RX_IN(RX_IN),
    .dat_samp_en(dat_samp_en),
    .Prescale(Prescale),
    .edge_cnt(edge_q),
    .sampled_bit(sampled_bit),
    .sample_vld(sample_vld)
  );
endmodule
